// File: rtl/mcs51_pkg.sv
// Shared types and constants for the MCS-51 timer/counter bank.
// Mode encoding, CTRL/STAT bit positions and per-channel register offsets.
package mcs51_pkg;

  typedef enum logic [1:0] {
    TMR_MODE_FREE    = 2'd0,
    TMR_MODE_RELOAD  = 2'd1,
    TMR_MODE_CAPTURE = 2'd2,
    TMR_MODE_ONESHOT = 2'd3
  } tmr_mode_e;

  localparam int CTRL_TR      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_CT      = 3;
  localparam int CTRL_GATE    = 4;
  localparam int CTRL_CAPEDGE = 5;
  localparam int CTRL_IE      = 6;

  localparam int STAT_TF  = 0;
  localparam int STAT_CF  = 1;
  localparam int STAT_OVR = 2;

  localparam logic [2:0] TMR_OFS_CTRL  = 3'd0;
  localparam logic [2:0] TMR_OFS_CNT_L = 3'd1;
  localparam logic [2:0] TMR_OFS_CNT_H = 3'd2;
  localparam logic [2:0] TMR_OFS_RLD_L = 3'd3;
  localparam logic [2:0] TMR_OFS_RLD_H = 3'd4;
  localparam logic [2:0] TMR_OFS_CAP_L = 3'd5;
  localparam logic [2:0] TMR_OFS_CAP_H = 3'd6;
  localparam logic [2:0] TMR_OFS_STAT  = 3'd7;

endpackage

// File: rtl/mcs51_timer_chan.sv
// One timer/counter channel: registers, edge detect, mode logic,
// and the 16-bit coherency shadows.
module mcs51_timer_chan
  import mcs51_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ptick_i,
  input  logic       cnt_in_i,
  input  logic       gate_in_i,
  input  logic       cap_in_i,
  input  logic       we_i,
  input  logic [2:0] wofs_i,
  input  logic [7:0] wdata_i,
  input  logic       re_i,
  input  logic [2:0] rofs_i,
  input  logic       ack_i,
  output logic [7:0] rdata_o,
  output logic       irq_o
);

  logic [6:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rld_q, rld_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             tf_q, tf_d;
  logic             cf_q, cf_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       cnt_rsh_q, cnt_rsh_d;
  logic [7:0]       cap_rsh_q, cap_rsh_d;
  logic [7:0]       cnt_wsh_q, cnt_wsh_d;
  logic             cnt_prev_q;
  logic             cap_prev_q;

  logic [15:0] cnt16, rld16, cap16;
  tmr_mode_e   mode;
  logic        cnt_fall, cap_edge;
  logic        tick, ovf, cap_ev;

  assign cnt16 = 16'(cnt_q);
  assign rld16 = 16'(rld_q);
  assign cap16 = 16'(cap_q);
  assign mode  = tmr_mode_e'(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);

  assign cnt_fall = cnt_prev_q & ~cnt_in_i;
  assign cap_edge = ctrl_q[CTRL_CAPEDGE] ? (~cap_prev_q & cap_in_i)
                                         : (cap_prev_q & ~cap_in_i);
  assign tick = ctrl_q[CTRL_TR]
              & (~ctrl_q[CTRL_GATE] | gate_in_i)
              & (ctrl_q[CTRL_CT] ? cnt_fall : ptick_i);
  assign ovf    = tick & (cnt_q == '1);
  assign cap_ev = (mode == TMR_MODE_CAPTURE) & cap_edge;

  always_comb begin
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    cap_d     = cap_q;
    tf_d      = tf_q;
    cf_d      = cf_q;
    ovr_d     = ovr_q;
    cnt_rsh_d = cnt_rsh_q;
    cap_rsh_d = cap_rsh_q;
    cnt_wsh_d = cnt_wsh_q;

    if (tick) begin
      if (!ovf) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        unique case (mode)
          TMR_MODE_FREE,
          TMR_MODE_CAPTURE: cnt_d = '0;
          TMR_MODE_RELOAD:  cnt_d = rld_q;
          TMR_MODE_ONESHOT: begin
            cnt_d           = rld_q;
            ctrl_d[CTRL_TR] = 1'b0;
          end
        endcase
      end
    end

    if (cap_ev) cap_d = cnt_q;

    if (ack_i) tf_d = 1'b0;

    // CPU writes land after the tick so they win the same cycle
    if (we_i) begin
      case (wofs_i)
        TMR_OFS_CTRL:  ctrl_d    = wdata_i[6:0];
        TMR_OFS_CNT_L: cnt_d     = CNT_W'({cnt_wsh_q, wdata_i});
        TMR_OFS_CNT_H: cnt_wsh_d = wdata_i;
        TMR_OFS_RLD_L: rld_d     = CNT_W'({rld16[15:8], wdata_i});
        TMR_OFS_RLD_H: rld_d     = CNT_W'({wdata_i, rld16[7:0]});
        TMR_OFS_STAT: begin
          if (wdata_i[STAT_TF])  tf_d  = 1'b0;
          if (wdata_i[STAT_CF])  cf_d  = 1'b0;
          if (wdata_i[STAT_OVR]) ovr_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (ovf) tf_d = 1'b1;
    if (cap_ev) begin
      cf_d = 1'b1;
      if (cf_q) ovr_d = 1'b1;
    end

    if (re_i && rofs_i == TMR_OFS_CNT_L) cnt_rsh_d = cnt16[15:8];
    if (re_i && rofs_i == TMR_OFS_CAP_L) cap_rsh_d = cap16[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      cnt_q      <= '0;
      rld_q      <= '0;
      cap_q      <= '0;
      tf_q       <= 1'b0;
      cf_q       <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_rsh_q  <= '0;
      cap_rsh_q  <= '0;
      cnt_wsh_q  <= '0;
      cnt_prev_q <= 1'b1;
      cap_prev_q <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      rld_q      <= rld_d;
      cap_q      <= cap_d;
      tf_q       <= tf_d;
      cf_q       <= cf_d;
      ovr_q      <= ovr_d;
      cnt_rsh_q  <= cnt_rsh_d;
      cap_rsh_q  <= cap_rsh_d;
      cnt_wsh_q  <= cnt_wsh_d;
      cnt_prev_q <= cnt_in_i;
      cap_prev_q <= cap_in_i;
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    case (rofs_i)
      TMR_OFS_CTRL:  rdata_o = {1'b0, ctrl_q};
      TMR_OFS_CNT_L: rdata_o = cnt16[7:0];
      TMR_OFS_CNT_H: rdata_o = cnt_rsh_q;
      TMR_OFS_RLD_L: rdata_o = rld16[7:0];
      TMR_OFS_RLD_H: rdata_o = rld16[15:8];
      TMR_OFS_CAP_L: rdata_o = cap16[7:0];
      TMR_OFS_CAP_H: rdata_o = cap_rsh_q;
      TMR_OFS_STAT:  rdata_o = {5'b0, ovr_q, cf_q, tf_q};
      default:       rdata_o = 8'h00;
    endcase
  end

  assign irq_o = ctrl_q[CTRL_IE] & (tf_q | cf_q);

endmodule

// File: rtl/mcs51_timer_bank.sv
// Multi-channel timer/counter bank on the SFR bus.
// Optional shared prescaler enabled by MCS51_TMR_PRESCALER_EN.
module mcs51_timer_bank
  import mcs51_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] SFR_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        sfr_raddr,
  input  logic              sfr_re,
  output logic [7:0]        sfr_rdata,
  output logic              sfr_hit,
  input  logic [7:0]        sfr_waddr,
  input  logic [7:0]        sfr_wdata,
  input  logic              sfr_we,
  input  logic [NUM_CH-1:0] cnt_in,
  input  logic [NUM_CH-1:0] gate_in,
  input  logic [NUM_CH-1:0] cap_in,
  output logic              irq,
  output logic [2:0]        irq_ch,
  input  logic              irq_ack,
  input  logic [2:0]        irq_ack_ch
);

  localparam int NREG = 8 * NUM_CH;

  // 9-bit offsets so addresses below the base never alias into the bank
  logic [8:0] roff, woff;
  logic       rch_hit, wch_hit;
  logic       ptick;

  assign roff    = {1'b0, sfr_raddr} - {1'b0, SFR_BASE};
  assign woff    = {1'b0, sfr_waddr} - {1'b0, SFR_BASE};
  assign rch_hit = roff < 9'(NREG);
  assign wch_hit = woff < 9'(NREG);

  logic [7:0]        ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mcs51_timer_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .ptick_i  (ptick),
      .cnt_in_i (cnt_in[g]),
      .gate_in_i(gate_in[g]),
      .cap_in_i (cap_in[g]),
      .we_i     (sfr_we & wch_hit & (woff[8:3] == 6'(g))),
      .wofs_i   (woff[2:0]),
      .wdata_i  (sfr_wdata),
      .re_i     (sfr_re & rch_hit & (roff[8:3] == 6'(g))),
      .rofs_i   (roff[2:0]),
      .ack_i    (irq_ack & (irq_ack_ch == 3'(g))),
      .rdata_o  (ch_rdata[g]),
      .irq_o    (ch_irq[g])
    );
  end

`ifdef MCS51_TMR_PRESCALER_EN
  logic [7:0] presc_q, presc_d;
  logic [7:0] div_q, div_d;
  logic       presc_rhit, presc_whit;

  assign presc_rhit = roff == 9'(NREG);
  assign presc_whit = woff == 9'(NREG);
  assign ptick      = div_q == presc_q;

  always_comb begin
    presc_d = presc_q;
    div_d   = ptick ? 8'h00 : div_q + 8'h01;
    if (sfr_we && presc_whit) begin
      presc_d = sfr_wdata;
      div_d   = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end

  assign sfr_hit = rch_hit | presc_rhit;
`else
  assign ptick   = 1'b1;
  assign sfr_hit = rch_hit;
`endif

  always_comb begin
    sfr_rdata = 8'hFF;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rch_hit && roff[8:3] == 6'(c)) sfr_rdata = ch_rdata[c];
    end
`ifdef MCS51_TMR_PRESCALER_EN
    if (presc_rhit) sfr_rdata = presc_q;
`endif
  end

  always_comb begin
    irq    = |ch_irq;
    irq_ch = 3'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_irq[c]) irq_ch = 3'(c);
    end
  end

endmodule

// File: tb/tb_mcs51_timer_bank.sv
// Directed self-checking bench for mcs51_timer_bank.
// Channel c occupies 0xC0+8c; PRESC sits at 0xE0.
module tb_mcs51_timer_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sfr_raddr, sfr_rdata, sfr_waddr, sfr_wdata;
  logic       sfr_re, sfr_hit, sfr_we;
  logic [3:0] cnt_in, gate_in, cap_in;
  logic       irq, irq_ack;
  logic [2:0] irq_ch, irq_ack_ch;

  int checks = 0;
  int errors = 0;

  mcs51_timer_bank #(
    .NUM_CH  (4),
    .CNT_W   (16),
    .SFR_BASE(8'hC0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sfr_raddr (sfr_raddr),
    .sfr_re    (sfr_re),
    .sfr_rdata (sfr_rdata),
    .sfr_hit   (sfr_hit),
    .sfr_waddr (sfr_waddr),
    .sfr_wdata (sfr_wdata),
    .sfr_we    (sfr_we),
    .cnt_in    (cnt_in),
    .gate_in   (gate_in),
    .cap_in    (cap_in),
    .irq       (irq),
    .irq_ch    (irq_ch),
    .irq_ack   (irq_ack),
    .irq_ack_ch(irq_ack_ch)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sfr_waddr = a;
    sfr_wdata = d;
    sfr_we    = 1'b1;
    @(posedge clk); #1;
    sfr_we    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    sfr_raddr = a;
    sfr_re    = 1'b1;
    #1;
    d = sfr_rdata;
    @(posedge clk); #1;
    sfr_re = 1'b0;
  endtask

  task automatic ack(input logic [2:0] ch);
    irq_ack    = 1'b1;
    irq_ack_ch = ch;
    @(posedge clk); #1;
    irq_ack    = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    checks++;
    if (irq !== 1'b0 || irq_ch !== 3'd0) begin
      errors++;
      $display("FAIL reset_irq got %b/%0d exp 0/0", irq, irq_ch);
    end
    rd(8'hC0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %h exp 00", d);
    end
    rd(8'hDF, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_stat got %h exp 00", d);
    end
    sfr_raddr = 8'hC0; #1;
    checks++;
    if (sfr_hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_c0 got %b exp 1", sfr_hit);
    end
    sfr_raddr = 8'hBF; #1;
    checks++;
    if (sfr_hit !== 1'b0 || sfr_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL miss_bf got %b/%h exp 0/ff", sfr_hit, sfr_rdata);
    end
  endtask

  task automatic test_free;
    logic [7:0] d;
    wr(8'hC2, 8'hFF);
    wr(8'hC1, 8'hFE);
    wr(8'hC0, 8'h41);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1 || irq_ch !== 3'd0) begin
      errors++;
      $display("FAIL free_irq got %b/%0d exp 1/0", irq, irq_ch);
    end
    rd(8'hC1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL free_cnt_l got %h exp 00", d);
    end
    rd(8'hC2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL free_cnt_h got %h exp 00", d);
    end
    rd(8'hC7, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL free_stat got %h exp 01", d);
    end
    wr(8'hC0, 8'h00);
    wr(8'hC7, 8'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL free_w1c irq got %b exp 0", irq);
    end
  endtask

  task automatic test_reload;
    logic [7:0] d;
    wr(8'hCB, 8'hF0);
    wr(8'hCC, 8'hFF);
    wr(8'hCA, 8'hFF);
    wr(8'hC9, 8'hFF);
    wr(8'hC8, 8'h43);
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1 || irq_ch !== 3'd1) begin
      errors++;
      $display("FAIL rld_irq got %b/%0d exp 1/1", irq, irq_ch);
    end
    ack(3'd1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL rld_ack got %b exp 0", irq);
    end
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL rld_early got %b exp 0", irq);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL rld_second got %b exp 1", irq);
    end
    rd(8'hC9, d);
    checks++;
    if (d !== 8'hF0) begin
      errors++;
      $display("FAIL rld_cnt got %h exp f0", d);
    end
    wr(8'hC8, 8'h00);
    wr(8'hCF, 8'h01);
  endtask

  task automatic test_capture;
    logic [7:0] d;
    wr(8'hD2, 8'h12);
    wr(8'hD1, 8'h30);
    wr(8'hD0, 8'h45);
    repeat (4) @(posedge clk);
    #1;
    cap_in[2] = 1'b0;
    @(posedge clk); #1;
    wr(8'hD0, 8'h44);
    checks++;
    if (irq !== 1'b1 || irq_ch !== 3'd2) begin
      errors++;
      $display("FAIL cap_irq got %b/%0d exp 1/2", irq, irq_ch);
    end
    rd(8'hD5, d);
    checks++;
    if (d !== 8'h34) begin
      errors++;
      $display("FAIL cap_l got %h exp 34", d);
    end
    rd(8'hD6, d);
    checks++;
    if (d !== 8'h12) begin
      errors++;
      $display("FAIL cap_h got %h exp 12", d);
    end
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL cap_stat got %h exp 02", d);
    end
    cap_in[2] = 1'b1;
    @(posedge clk); #1;
    cap_in[2] = 1'b0;
    @(posedge clk); #1;
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h06) begin
      errors++;
      $display("FAIL cap_ovr got %h exp 06", d);
    end
    wr(8'hD7, 8'h06);
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL cap_w1c got %h/%b exp 00/0", d, irq);
    end
    cap_in[2] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_oneshot;
    logic [7:0] d;
    wr(8'hDB, 8'h55);
    wr(8'hDC, 8'h00);
    wr(8'hDA, 8'hFF);
    wr(8'hD9, 8'hFF);
    wr(8'hD8, 8'h47);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1 || irq_ch !== 3'd3) begin
      errors++;
      $display("FAIL os_irq got %b/%0d exp 1/3", irq, irq_ch);
    end
    rd(8'hD9, d);
    checks++;
    if (d !== 8'h55) begin
      errors++;
      $display("FAIL os_cnt_l got %h exp 55", d);
    end
    rd(8'hDA, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL os_cnt_h got %h exp 00", d);
    end
    rd(8'hD8, d);
    checks++;
    if (d !== 8'h46) begin
      errors++;
      $display("FAIL os_ctrl got %h exp 46", d);
    end
    wr(8'hDF, 8'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL os_clear got %b exp 0", irq);
    end
  endtask

  task automatic test_coherency;
    logic [7:0] d;
    wr(8'hC2, 8'h12);
    wr(8'hC1, 8'hFE);
    wr(8'hC0, 8'h01);
    @(posedge clk); #1;
    rd(8'hC1, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL coh_l got %h exp ff", d);
    end
    rd(8'hC2, d);
    checks++;
    if (d !== 8'h12) begin
      errors++;
      $display("FAIL coh_h got %h exp 12", d);
    end
    wr(8'hC0, 8'h00);
    wr(8'hC2, 8'hAB);
    rd(8'hC1, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL coh_hold got %h exp 02", d);
    end
    wr(8'hC1, 8'hCD);
    rd(8'hC1, d);
    checks++;
    if (d !== 8'hCD) begin
      errors++;
      $display("FAIL coh_wl got %h exp cd", d);
    end
    rd(8'hC2, d);
    checks++;
    if (d !== 8'hAB) begin
      errors++;
      $display("FAIL coh_wh got %h exp ab", d);
    end
  endtask

  task automatic test_ct_gate;
    logic [7:0] d;
    wr(8'hC0, 8'h09);
    repeat (3) begin
      cnt_in[0] = 1'b0;
      @(posedge clk); #1;
      cnt_in[0] = 1'b1;
      @(posedge clk); #1;
    end
    rd(8'hC1, d);
    checks++;
    if (d !== 8'hD0) begin
      errors++;
      $display("FAIL ct_count got %h exp d0", d);
    end
    wr(8'hC0, 8'h11);
    repeat (4) @(posedge clk);
    #1;
    rd(8'hC1, d);
    checks++;
    if (d !== 8'hD0) begin
      errors++;
      $display("FAIL gate_low got %h exp d0", d);
    end
    gate_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd(8'hC1, d);
    checks++;
    if (d !== 8'hD4) begin
      errors++;
      $display("FAIL gate_high got %h exp d4", d);
    end
    gate_in[0] = 1'b0;
    wr(8'hC0, 8'h00);
  endtask

  task automatic test_simultaneous;
    logic [7:0] d;
    wr(8'hCA, 8'hFF);
    wr(8'hC9, 8'hFF);
    wr(8'hDA, 8'hFF);
    wr(8'hD9, 8'hFF);
    wr(8'hC8, 8'h41);
    wr(8'hD8, 8'h41);
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1 || irq_ch !== 3'd1) begin
      errors++;
      $display("FAIL prio_both got %b/%0d exp 1/1", irq, irq_ch);
    end
    wr(8'hC8, 8'h40);
    wr(8'hCF, 8'h01);
    checks++;
    if (irq_ch !== 3'd3) begin
      errors++;
      $display("FAIL prio_ch3 got %0d exp 3", irq_ch);
    end
    wr(8'hCA, 8'hFF);
    wr(8'hC9, 8'hFF);
    wr(8'hC8, 8'h41);
    ack(3'd1);
    checks++;
    if (irq_ch !== 3'd1) begin
      errors++;
      $display("FAIL ack_race got %0d exp 1", irq_ch);
    end
    ack(3'd7);
    rd(8'hDF, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL ack_oob got %h exp 01", d);
    end
    ack(3'd1);
    checks++;
    if (irq_ch !== 3'd3) begin
      errors++;
      $display("FAIL ack_ch1 got %0d exp 3", irq_ch);
    end
    ack(3'd3);
    checks++;
    if (irq !== 1'b0 || irq_ch !== 3'd0) begin
      errors++;
      $display("FAIL ack_all got %b/%0d exp 0/0", irq, irq_ch);
    end
    wr(8'hC8, 8'h00);
    wr(8'hD8, 8'h00);
  endtask

  task automatic test_prescaler;
`ifdef MCS51_TMR_PRESCALER_EN
    logic [7:0] a, b;
    wr(8'hE0, 8'h03);
    sfr_raddr = 8'hE0; #1;
    checks++;
    if (sfr_hit !== 1'b1 || sfr_rdata !== 8'h03) begin
      errors++;
      $display("FAIL presc_rd got %b/%h exp 1/03", sfr_hit, sfr_rdata);
    end
    wr(8'hC2, 8'h00);
    wr(8'hC1, 8'h00);
    wr(8'hC0, 8'h01);
    rd(8'hC1, a);
    repeat (7) @(posedge clk);
    #1;
    rd(8'hC1, b);
    checks++;
    if (8'(b - a) !== 8'd2) begin
      errors++;
      $display("FAIL presc_rate got %0d exp 2", 8'(b - a));
    end
    wr(8'hC0, 8'h00);
    wr(8'hE0, 8'h00);
`else
    sfr_raddr = 8'hE0; #1;
    checks++;
    if (sfr_hit !== 1'b0 || sfr_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL presc_unmapped got %b/%h exp 0/ff", sfr_hit, sfr_rdata);
    end
`endif
  endtask

  task automatic test_reset_midrun;
    logic [7:0] d;
    wr(8'hD2, 8'h00);
    wr(8'hD1, 8'h00);
    wr(8'hD0, 8'h45);
    cap_in[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %b exp 1", irq);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (irq !== 1'b0 || irq_ch !== 3'd0) begin
      errors++;
      $display("FAIL mid_irq got %b/%0d exp 0/0", irq, irq_ch);
    end
    rd(8'hD0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_ctrl got %h exp 00", d);
    end
    rd(8'hD7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_stat got %h exp 00", d);
    end
    rd(8'hD5, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_cap got %h exp 00", d);
    end
    cap_in[2] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    sfr_raddr  = 8'h00;
    sfr_re     = 1'b0;
    sfr_waddr  = 8'h00;
    sfr_wdata  = 8'h00;
    sfr_we     = 1'b0;
    cnt_in     = 4'hF;
    gate_in    = 4'h0;
    cap_in     = 4'hF;
    irq_ack    = 1'b0;
    irq_ack_ch = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_free;
    test_reload;
    test_capture;
    test_oneshot;
    test_coherency;
    test_ct_gate;
    test_simultaneous;
    test_prescaler;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
